// File: rtl/root_ch_array_pkg.sv
// Shared types and helpers for the root channel array.
// Holds the channel-index width and leaf count-width calculations, the
// channel index type, and the round-robin pointer increment with wrap.
package root_ch_array_pkg;

  // Wide enough for any practical channel count; tops slice to CH_W.
  localparam int MAX_CH_W = 16;

  typedef logic [MAX_CH_W-1:0] ch_idx_t;

  // Channel select width: at least one bit even for a single channel.
  function automatic int ch_w_calc(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Occupancy counter width: must be able to hold the value DEPTH itself.
  function automatic int cnt_w_calc(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Next round-robin start position after index cur, wrapping at num_ch.
  function automatic ch_idx_t rr_inc(input ch_idx_t cur, input int num_ch);
    ch_idx_t nxt;
    nxt = cur + ch_idx_t'(1);
    return (int'(nxt) >= num_ch) ? '0 : nxt;
  endfunction

endpackage

// File: rtl/root_ch_leaf.sv
// Single-channel FIFO leaf: DEPTH x DATA_W storage with push, pop, head,
// empty, full and count. DEPTH need not be a power of two; pointers wrap
// explicitly. The head is read asynchronously so an entry written at one
// edge is presented right after it.
module root_ch_leaf
  import root_ch_array_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 4,
  localparam int CNT_W  = cnt_w_calc(DEPTH),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              push_en;
  logic              pop_en;

  // Pointer advance with wrap at DEPTH (not a power-of-two mask).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  // A full leaf never accepts, even if it is popped in the same cycle.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

  // Storage write; left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_en)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push_en && !pop_en)      count_reg <= count_reg + 1'b1;
      else if (!push_en && pop_en) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/root_channel_array.sv
// Top of the channel hierarchy: NUM_CH generated FIFO leaves merged onto one
// valid/ready output by a round-robin arbiter. Requests to a channel index
// >= NUM_CH are accepted, discarded and flagged on drop_pulse a cycle later.
// Optional macro ROOT_CH_ARRAY_BYPASS_EN: when every leaf is empty and the
// consumer is ready, an in-range request passes straight to the output in
// the same cycle without being stored.
module root_channel_array
  import root_ch_array_pkg::*;
#(
  parameter int  NUM_CH = 5,
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 4,
  localparam int CH_W   = ch_w_calc(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CH_W-1:0]   req_ch,
  input  logic [DATA_W-1:0] req_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              drop_pulse
);

  localparam int CNT_W = cnt_w_calc(DEPTH);

  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] push_vec;
  logic [NUM_CH-1:0] pop_vec;
  logic [NUM_CH-1:0] empty_vec;
  logic [NUM_CH-1:0] full_vec;
  logic [NUM_CH-1:0] rot_valid;
  logic [DATA_W-1:0] head_arr [NUM_CH];
  logic [CNT_W-1:0]  leaf_count [NUM_CH];
  logic [DATA_W-1:0] head_sel;
  ch_idx_t           rr_ptr_reg;
  ch_idx_t           rr_ptr_next;
  ch_idx_t           grant;
  logic              grant_found;
  logic              in_range;
  logic              any_valid;
  logic              bypass_fire;
  logic              handshake;
  logic              drop_pulse_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : gen_leaf
      assign ch_sel[gi]   = (int'(req_ch) == gi);
      assign push_vec[gi] = req_valid && ch_sel[gi] && !full_vec[gi] && !bypass_fire;
      assign pop_vec[gi]  = handshake && !bypass_fire && (grant == ch_idx_t'(gi));

      root_ch_leaf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_leaf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_vec[gi]),
        .push_data (req_data),
        .pop       (pop_vec[gi]),
        .head      (head_arr[gi]),
        .empty     (empty_vec[gi]),
        .full      (full_vec[gi]),
        .count     (leaf_count[gi])
      );

      // Occupancy stays within DEPTH and agrees with the empty flag.
      always_comb begin
        assert (!rst_n || ((leaf_count[gi] <= CNT_W'(DEPTH)) &&
                           ((leaf_count[gi] == '0) == empty_vec[gi])));
      end
    end
  endgenerate

  // Out-of-range channels are always accepted (and discarded).
  assign in_range  = |ch_sel;
  assign req_ready = !in_range || |(ch_sel & ~full_vec);
  assign any_valid = !(&empty_vec);

`ifdef ROOT_CH_ARRAY_BYPASS_EN
  assign bypass_fire = (&empty_vec) && req_valid && in_range && out_ready;
`else
  assign bypass_fire = 1'b0;
`endif

  // Non-empty flags rotated so bit k is leaf (rr_ptr + k) mod NUM_CH.
  assign rot_valid = NUM_CH'({~empty_vec, ~empty_vec} >> rr_ptr_reg);

  // Grant the first non-empty leaf at or after rr_ptr.
  always_comb begin
    grant       = rr_ptr_reg;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!grant_found && rot_valid[k]) begin
        grant_found = 1'b1;
        grant       = ch_idx_t'((int'(rr_ptr_reg) + k) % NUM_CH);
      end
    end
  end

  // Head of the granted leaf.
  always_comb begin
    head_sel = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (grant == ch_idx_t'(j)) head_sel = head_arr[j];
    end
  end

  assign out_valid = any_valid || bypass_fire;
  assign out_ch    = bypass_fire ? req_ch : grant[CH_W-1:0];
  assign out_data  = bypass_fire ? req_data : head_sel;
  assign handshake = out_valid && out_ready;

  // Round-robin start moves past whichever channel was just served.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (bypass_fire)    rr_ptr_next = rr_inc(ch_idx_t'(req_ch), NUM_CH);
    else if (handshake) rr_ptr_next = rr_inc(grant, NUM_CH);
  end

  // Arbiter pointer and drop indication registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg     <= '0;
      drop_pulse_reg <= 1'b0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      drop_pulse_reg <= req_valid && !in_range;
    end
  end

  assign drop_pulse = drop_pulse_reg;

endmodule

// File: tb/tb_root_channel_array.sv
// Self-checking bench for root_channel_array (NUM_CH=5, DATA_W=8, DEPTH=4).
// A queue-per-channel model predicts every output each cycle; directed
// sections pin the model with hand-computed literals; a random phase follows.
// Honours ROOT_CH_ARRAY_BYPASS_EN the same way as the design.
module tb_root_channel_array;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 3;
`ifdef ROOT_CH_ARRAY_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [CH_W-1:0]   req_ch = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic              drop_pulse;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [DATA_W-1:0] mq [NUM_CH][$];
  int                m_rr = 0;
  bit                m_drop = 1'b0;

  // Handshakes observed on the DUT output
  int log_ch[$];
  int log_data[$];

  root_channel_array #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ch     (req_ch),
    .req_data   (req_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_count();
    int s = 0;
    for (int k = 0; k < NUM_CH; k++) s += mq[k].size();
    return s;
  endfunction

  // Expected outputs from the model queues and the current inputs.
  function automatic void model_out(output bit v, output int ch, output logic [DATA_W-1:0] d,
                                    output bit byp, output bit rdy);
    bit any;
    bit inr;
    int c;
    any = 1'b0;
    ch  = 0;
    d   = '0;
    inr = (int'(req_ch) < NUM_CH);
    rdy = 1'b1;
    if (inr) rdy = (mq[int'(req_ch)].size() < DEPTH);
    for (int k = 0; k < NUM_CH; k++) begin
      c = (m_rr + k) % NUM_CH;
      if (!any && mq[c].size() > 0) begin
        any = 1'b1;
        ch  = c;
        d   = mq[c][0];
      end
    end
    byp = BYPASS && !any && req_valid && inr && out_ready;
    if (byp) begin
      ch = int'(req_ch);
      d  = req_data;
    end
    v = any || byp;
  endfunction

  // Compare process: every cycle, mid-period, against the model.
  always @(negedge clk) begin
    bit                v, byp, rdy;
    int                ch;
    logic [DATA_W-1:0] d;
    if (chk_en) begin
      model_out(v, ch, d, byp, rdy);
      check("out_valid", 32'(out_valid), 32'(v));
      if (v) begin
        check("out_ch", 32'(out_ch), ch);
        check("out_data", 32'(out_data), 32'(d));
      end
      check("req_ready", 32'(req_ready), 32'(rdy));
      check("drop_pulse", 32'(drop_pulse), 32'(m_drop));
      if (out_valid && out_ready) begin
        log_ch.push_back(int'(out_ch));
        log_data.push_back(int'(out_data));
        $display("xfer ch=%0d data=%02h t=%0t", out_ch, out_data, $time);
      end
    end
  end

  // Model update at each rising edge from the inputs presented that cycle.
  always @(posedge clk) begin
    bit                v, byp, rdy, inr;
    int                ch;
    logic [DATA_W-1:0] d;
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) mq[k].delete();
      m_rr   = 0;
      m_drop = 1'b0;
    end else begin
      model_out(v, ch, d, byp, rdy);
      inr    = (int'(req_ch) < NUM_CH);
      m_drop = req_valid && !inr;
      if (byp) m_rr = (int'(req_ch) + 1) % NUM_CH;
      else if (v && out_ready) begin
        void'(mq[ch].pop_front());
        m_rr = (ch + 1) % NUM_CH;
      end
      if (req_valid && inr && rdy && !byp) mq[int'(req_ch)].push_back(req_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int d);
    req_valid = 1'b1;
    req_ch    = CH_W'(ch);
    req_data  = DATA_W'(d);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    out_ready = 1'b1;
    while (model_count() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    check("drain_within_bound", 32'(n < 50), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic check_log(input string name, input int ec[$], input int ed[$]);
    check({name, "_len"}, log_ch.size(), ec.size());
    for (int i = 0; i < ec.size() && i < log_ch.size(); i++) begin
      check({name, "_ch"}, log_ch[i], ec[i]);
      check({name, "_data"}, log_data[i], ed[i]);
    end
  endtask

  initial begin
    int ec[$];
    int ed[$];

    // Reset, then idle
    rst_n = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_drop", 32'(drop_pulse), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_rr_ptr", 32'(dut.rr_ptr_reg), 32'd0);
    for (int i = 0; i < NUM_CH; i++) check("rst_count", 32'(dut.leaf_count[i]), 32'd0);

    // Round-robin order across ch0, ch2, ch4
    tick();
    log_ch.delete();
    log_data.delete();
    push(0, 'hA0);
    push(2, 'hA1);
    push(4, 'hA2);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    ec = '{0, 2, 4};
    ed = '{'hA0, 'hA1, 'hA2};
    check_log("rr_order", ec, ed);
    check("rr_ptr_wrap", 32'(dut.rr_ptr_reg), 32'd0);

    // Full leaf: four entries in ch1, no pass-through while popping
    for (int i = 0; i < 4; i++) push(1, 'hB0 + i);
    req_ch = 3'd1;
    @(negedge clk);
    check("full_ready_ch1", 32'(req_ready), 32'd0);
    check("full_count_ch1", 32'(dut.leaf_count[1]), 32'd4);
    req_ch = 3'd3;
    #1;
    check("full_ready_ch3", 32'(req_ready), 32'd1);
    tick();
    log_ch.delete();
    log_data.delete();
    out_ready = 1'b1;
    req_valid = 1'b1;
    req_ch    = 3'd1;
    req_data  = 8'hB4;
    @(negedge clk);
    check("full_pop_blocks", 32'(req_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("full_freed_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    drain();
    ec = '{1, 1, 1, 1, 1};
    ed = '{'hB0, 'hB1, 'hB2, 'hB3, 'hB4};
    check_log("full_order", ec, ed);

    // Out-of-range request is dropped with a one-cycle pulse
    log_ch.delete();
    log_data.delete();
    push(6, 'h77);
    @(negedge clk);
    check("oor_drop_hi", 32'(drop_pulse), 32'd1);
    check("oor_no_out", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("oor_drop_lo", 32'(drop_pulse), 32'd0);
    check("oor_nothing_emitted", log_ch.size(), 32'd0);
    tick();

    // Concurrent push and pop on ch3 holding two entries
    push(3, 'hC0);
    push(3, 'hC1);
    log_ch.delete();
    log_data.delete();
    req_valid = 1'b1;
    req_ch    = 3'd3;
    req_data  = 8'hC2;
    out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("conc_count", 32'(dut.leaf_count[3]), 32'd2);
    tick();
    drain();
    ec = '{3, 3, 3};
    ed = '{'hC0, 'hC1, 'hC2};
    check_log("conc_order", ec, ed);

    // Empty-path request with the consumer ready
    req_valid = 1'b1;
    req_ch    = 3'd2;
    req_data  = 8'h5C;
    out_ready = 1'b1;
    @(negedge clk);
    if (BYPASS) begin
      check("byp_valid_same", 32'(out_valid), 32'd1);
      check("byp_ch", 32'(out_ch), 32'd2);
      check("byp_data", 32'(out_data), 32'h5C);
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      check("byp_not_stored", 32'(dut.leaf_count[2]), 32'd0);
      check("byp_no_repeat", 32'(out_valid), 32'd0);
    end else begin
      check("lat_valid_same", 32'(out_valid), 32'd0);
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      check("lat_valid_next", 32'(out_valid), 32'd1);
      check("lat_ch", 32'(out_ch), 32'd2);
      check("lat_data", 32'(out_data), 32'h5C);
    end
    tick();
    out_ready = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_ch    = CH_W'($urandom_range(0, 7));
      req_data  = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Mid-stream reset with three entries stored
    push(0, 'h11);
    push(1, 'h22);
    push(0, 'h33);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    log_ch.delete();
    log_data.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    check("midrst_nothing_emitted", log_ch.size(), 32'd0);
    check("midrst_count0", 32'(dut.leaf_count[0]), 32'd0);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
